peecc_decoder: RTL and testbench
================================

Name: peecc_decoder

Overview:
Receive-side SEC-DED decoder for the PEECC link. It accepts 18-bit Hamming(17,12)+overall-parity codewords from the channel and corrects any single-bit error. It flags double or invalid errors, delivers the 12-bit payload through a 2-stage valid/ready pipeline, and keeps saturating error statistics for the top-level checker.

Parameters:
- DATA_W, 12: payload width. Fixed by the code layout; other values are unsupported.
- CW_W, 18: codeword width. Bit 0 is overall parity; bits 1..17 are Hamming positions.
- CNT_W, 16: width of the error counters.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- ValidIn  in  1  codeword valid from the channel
- ReadyOut  out  1  decoder can accept a codeword
- CodeIn  in  18  received codeword
- ValidOut  out  1  decoded word valid
- ReadyIn  in  1  downstream accepts the decoded word
- DataOut  out  12  corrected payload
- Corrected  out  1  single error fixed in this word
- Uncorrectable  out  1  double or invalid error in this word; DataOut is raw
- ErrPos  out  5  corrected bit position (0..17); 0 when Corrected=0
- ClrCnt  in  1  synchronous clear of both counters
- CorrCnt  out  16  count of corrected words, saturating
- UncCnt  out  16  count of uncorrectable words, saturating

Behaviour:
- Code layout:
  - Parity bits sit at positions 1, 2, 4, 8 and 16.
  - Data bits d[0..11] sit at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, in ascending order.
  - Encoding uses even parity, so a valid codeword has syndrome 0 and overall XOR 0.
- Stage 1 captures CodeIn and computes:
  - S[4:0] = XOR of every index k (1..17) where CodeIn[k]=1.
  - P = XOR of all 18 bits.
- Stage 2 classification:
  - S=0, P=0: clean.
  - P=1, S=0: error in bit 0. Corrected=1, ErrPos=0, data unchanged.
  - P=1, S in 1..17: flip bit S. Corrected=1, ErrPos=S.
  - P=1, S in 18..31: Uncorrectable=1.
  - P=0, S≠0: Uncorrectable=1 (double error).
  - Corrected and Uncorrectable are never both 1.
- Handshake:
  - A transfer occurs when Valid and Ready are both 1 on a rising edge.
  - Each stage loads when it is empty or its contents are leaving in the same cycle.
  - ReadyOut = !s1_valid || s1_advance. This is combinational from ReadyIn, with no registered skid.
  - Latency is 2 cycles from input transfer to ValidOut with no stall; throughput is 1 word per cycle.
  - DataOut, Corrected, Uncorrectable and ErrPos are stable while ValidOut=1 and ReadyIn=0.
- Counters:
  - Increment on the output transfer, not on stage capture, so a stalled word is counted once.
  - Saturate at 16'hFFFF.
  - ClrCnt has priority over a simultaneous increment; both counters read 0 next cycle.
- Reset, asynchronous on RST_N low:
  - Stage valids cleared, so ValidOut=0.
  - DataOut=0, Corrected=0, Uncorrectable=0, ErrPos=0, CorrCnt=0, UncCnt=0.
  - ReadyOut=1 once reset is released.
  - Words in flight are discarded and never counted. No output appears until new input arrives.
- ValidIn=0 while ReadyOut=1: no state change beyond drain.

Test Plan:
- Clean stream: reset low 2 cycles, then CodeIn=18'h00000 with ValidIn=1 and ReadyIn=1 held -> ValidOut first rises 2 cycles after the first transfer, DataOut=12'h000, flags 0, counters 0.
- Single error: 18'h00020 -> DataOut=0, Corrected=1, ErrPos=5, CorrCnt=1. Then 18'h00001 -> Corrected=1, ErrPos=0, CorrCnt=2.
- Uncorrectable:
  - 18'h00006 (S=3, P=0) -> Uncorrectable=1, ErrPos=0, UncCnt=1.
  - 18'h10005 (S=18, P=1) -> Uncorrectable=1, UncCnt=2.
- Backpressure: stream 4 error-free words, ReadyIn=0 for 3 cycles after the first ValidOut -> ReadyOut drops once both stages fill, outputs hold, no loss or duplication, all 4 words delivered in order.
- Saturation and clear:
  - Force CorrCnt to 16'hFFFE via 2 corrected words after preloading -> holds at 16'hFFFF.
  - ClrCnt coincident with a corrected output transfer -> CorrCnt=0.
- Mid-operation reset: assert RST_N=0 with both stages full -> ValidOut=0 immediately (asynchronous), counters 0, no stale word after release.

Source files
------------

// File: rtl/peecc_decoder.sv
// peecc_decoder: SEC-DED Hamming(17,12)+overall-parity decoder with a 2-stage
// valid/ready pipeline and saturating corrected/uncorrectable word counters.
module peecc_decoder #(
    parameter int DATA_W = 12,
    parameter int CW_W   = 18,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ValidIn,
    output logic              ReadyOut,
    input  logic [CW_W-1:0]   CodeIn,
    output logic              ValidOut,
    input  logic              ReadyIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Corrected,
    output logic              Uncorrectable,
    output logic [4:0]        ErrPos,
    input  logic              ClrCnt,
    output logic [CNT_W-1:0]  CorrCnt,
    output logic [CNT_W-1:0]  UncCnt
);
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [CW_W-1:0]   s1_code_q, flip, fixed;
    logic [4:0]        s1_syn_q, syn, pos_d;
    logic              s1_par_q, in_fire, s1_adv, s2_fire, corr_d, unc_d;
    logic [DATA_W-1:0] data_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d, unc_cnt_q, unc_cnt_d;
    logic              corr_q, unc_q;
    logic [DATA_W-1:0] data_q;
    logic [4:0]        pos_q;

    always_comb begin
        syn = '0;
        for (int k = 1; k < CW_W; k++) syn ^= CodeIn[k] ? 5'(k) : 5'd0;
    end

    assign s2_fire  = s2_valid_q & ReadyIn;
    assign s1_adv   = s1_valid_q & (!s2_valid_q | ReadyIn);
    assign ReadyOut = !s1_valid_q | s1_adv;
    assign in_fire  = ValidIn & ReadyOut;

    // Odd overall parity with an in-range syndrome is a single error; syndrome 0 means bit 0 itself.
    assign corr_d = s1_par_q & (s1_syn_q <= 5'd17);
    assign unc_d  = (s1_syn_q != 5'd0) & !corr_d;
    assign pos_d  = corr_d ? s1_syn_q : 5'd0;
    assign flip   = corr_d ? ({{(CW_W-1){1'b0}}, 1'b1} << s1_syn_q) : '0;
    assign fixed  = s1_code_q ^ flip;
    assign data_d = {fixed[17], fixed[15:9], fixed[7:5], fixed[3]};

    assign s1_valid_d = in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    assign s2_valid_d = s1_adv ? 1'b1 : (s2_fire ? 1'b0 : s2_valid_q);
    assign corr_cnt_d = ClrCnt ? '0 : corr_cnt_q + CNT_W'(s2_fire & corr_q & ~&corr_cnt_q);
    assign unc_cnt_d  = ClrCnt ? '0 : unc_cnt_q + CNT_W'(s2_fire & unc_q & ~&unc_cnt_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            data_q     <= '0;
            corr_q     <= 1'b0;
            unc_q      <= 1'b0;
            pos_q      <= '0;
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            corr_cnt_q <= corr_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
            if (in_fire) begin
                s1_code_q <= CodeIn;
                s1_syn_q  <= syn;
                s1_par_q  <= ^CodeIn;
            end
            if (s1_adv) begin
                data_q <= data_d;
                corr_q <= corr_d;
                unc_q  <= unc_d;
                pos_q  <= pos_d;
            end
        end
    end

    assign ValidOut      = s2_valid_q;
    assign DataOut       = data_q;
    assign Corrected     = corr_q;
    assign Uncorrectable = unc_q;
    assign ErrPos        = pos_q;
    assign CorrCnt       = corr_cnt_q;
    assign UncCnt        = unc_cnt_q;
endmodule

// File: tb/tb_peecc_decoder.sv
// tb_peecc_decoder: directed vector table plus hand-written stall, saturation,
// clear and mid-operation reset sequences for peecc_decoder.
module tb_peecc_decoder;
    typedef struct {
        logic [17:0] code;
        logic [11:0] data;
        logic        corr;
        logic        unc;
        logic [4:0]  pos;
    } vec_t;

    logic        CLK = 1'b0, RST_N = 1'b0, ValidIn = 1'b0, ReadyIn = 1'b0, ClrCnt = 1'b0;
    logic [17:0] CodeIn = '0;
    logic        ReadyOut, ValidOut, Corrected, Uncorrectable;
    logic [11:0] DataOut;
    logic [4:0]  ErrPos;
    logic [15:0] CorrCnt, UncCnt;
    int          tests = 0, fails = 0;
    logic [15:0] exp_cc = '0, exp_uc = '0;
    vec_t        vecs[14];

    peecc_decoder dut (
        .CLK(CLK), .RST_N(RST_N), .ValidIn(ValidIn), .ReadyOut(ReadyOut), .CodeIn(CodeIn),
        .ValidOut(ValidOut), .ReadyIn(ReadyIn), .DataOut(DataOut), .Corrected(Corrected),
        .Uncorrectable(Uncorrectable), .ErrPos(ErrPos), .ClrCnt(ClrCnt),
        .CorrCnt(CorrCnt), .UncCnt(UncCnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with an empty pipeline; leaves it empty again.
    task automatic run_vec(input vec_t v, input string tag);
        ValidIn = 1'b1;
        CodeIn  = v.code;
        ReadyIn = 1'b1;
        @(negedge CLK);
        ValidIn = 1'b0;
        chk({tag, " early"}, ValidOut, 1'b0);
        @(negedge CLK);
        chk({tag, " valid"}, ValidOut, 1'b1);
        chk({tag, " data"}, DataOut, v.data);
        chk({tag, " corr"}, Corrected, v.corr);
        chk({tag, " unc"}, Uncorrectable, v.unc);
        chk({tag, " pos"}, ErrPos, v.pos);
        if (v.corr && exp_cc != 16'hFFFF) exp_cc++;
        if (v.unc && exp_uc != 16'hFFFF) exp_uc++;
        @(negedge CLK);
        chk({tag, " drained"}, ValidOut, 1'b0);
        chk({tag, " corrcnt"}, CorrCnt, exp_cc);
        chk({tag, " unccnt"}, UncCnt, exp_uc);
    endtask

    initial begin
        logic [17:0] bp_code[4];
        logic [11:0] bp_data[4];
        logic [11:0] rcv[4];
        int          sent, got, outs, stall, low_cnt;
        logic        seen, in_f;

        vecs[0]  = '{18'h00020, 12'h000, 1'b1, 1'b0, 5'd5};
        vecs[1]  = '{18'h00001, 12'h000, 1'b1, 1'b0, 5'd0};
        vecs[2]  = '{18'h00006, 12'h000, 1'b0, 1'b1, 5'd0};
        vecs[3]  = '{18'h10005, 12'h000, 1'b0, 1'b1, 5'd0};
        vecs[4]  = '{18'h0000F, 12'h001, 1'b0, 1'b0, 5'd0};
        vecs[5]  = '{18'h30003, 12'h800, 1'b0, 1'b0, 5'd0};
        vecs[6]  = '{18'h3FFFC, 12'hFFF, 1'b0, 1'b0, 5'd0};
        vecs[7]  = '{18'h3FDFC, 12'hFFF, 1'b1, 1'b0, 5'd9};
        vecs[8]  = '{18'h00007, 12'h001, 1'b1, 1'b0, 5'd3};
        vecs[9]  = '{18'h10003, 12'h800, 1'b1, 1'b0, 5'd17};
        vecs[10] = '{18'h3FFFF, 12'hFFF, 1'b0, 1'b1, 5'd0};
        vecs[11] = '{18'h00027, 12'h002, 1'b0, 1'b1, 5'd0};
        vecs[12] = '{18'h3FFFD, 12'hFFF, 1'b1, 1'b0, 5'd0};
        vecs[13] = '{18'h10009, 12'h001, 1'b0, 1'b1, 5'd0};
        bp_code = '{18'h0000F, 18'h30003, 18'h3FFFC, 18'h00000};
        bp_data = '{12'h001, 12'h800, 12'hFFF, 12'h000};

        // Reset and clean stream
        repeat (2) @(negedge CLK);
        chk("rst validout", ValidOut, 1'b0);
        chk("rst data", DataOut, 12'h000);
        chk("rst flags", {Corrected, Uncorrectable}, 2'b00);
        chk("rst errpos", ErrPos, 5'd0);
        chk("rst cnts", {CorrCnt, UncCnt}, 32'h0);
        RST_N   = 1'b1;
        #1;
        chk("rst readyout", ReadyOut, 1'b1);
        ValidIn = 1'b1;
        CodeIn  = 18'h00000;
        ReadyIn = 1'b1;
        @(negedge CLK);
        chk("clean lat1", ValidOut, 1'b0);
        @(negedge CLK);
        chk("clean lat2", ValidOut, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("clean valid", ValidOut, 1'b1);
            chk("clean data", DataOut, 12'h000);
            chk("clean flags", {Corrected, Uncorrectable, ErrPos}, 7'h0);
        end
        ValidIn = 1'b0;
        repeat (3) @(negedge CLK);
        chk("clean drained", ValidOut, 1'b0);
        chk("clean cnts", {CorrCnt, UncCnt}, 32'h0);

        // Vector table
        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: 4 clean words, ReadyIn low for 3 cycles after first ValidOut
        sent = 0; got = 0; outs = 0; stall = 0; low_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ValidOut && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            ReadyIn = (stall == 0);
            ValidIn = (sent < 4);
            CodeIn  = bp_code[(sent < 4) ? sent : 0];
            #1;
            if (!ReadyIn) begin
                if (!ReadyOut) low_cnt++;
                chk("bp hold data", DataOut, 12'h001);
                chk("bp hold valid", ValidOut, 1'b1);
            end
            if (ValidOut && ReadyIn) begin
                if (outs < 4) rcv[outs] = DataOut;
                outs++;
            end
            in_f = ValidIn && ReadyOut;
            if (stall > 0) stall--;
            @(negedge CLK);
            if (in_f) sent++;
        end
        ValidIn = 1'b0;
        got = outs;
        chk("bp stall readyout low", low_cnt, 3);
        chk("bp words out", got, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp order%0d", i), rcv[i], bp_data[i]);
        chk("bp cnts", {CorrCnt, UncCnt}, {exp_cc, exp_uc});

        // Clear, then saturate CorrCnt
        ClrCnt = 1'b1;
        @(negedge CLK);
        ClrCnt = 1'b0;
        chk("clr corrcnt", CorrCnt, 16'h0);
        chk("clr unccnt", UncCnt, 16'h0);
        exp_cc  = '0;
        exp_uc  = '0;
        ReadyIn = 1'b1;
        ValidIn = 1'b1;
        CodeIn  = 18'h00001;
        repeat (65534) @(negedge CLK);
        ValidIn = 1'b0;
        repeat (2) @(negedge CLK);
        chk("sat preload", CorrCnt, 16'hFFFE);
        chk("sat preload unc", UncCnt, 16'h0);
        exp_cc = 16'hFFFE;
        run_vec(vecs[0], "sat1");
        chk("sat reach", CorrCnt, 16'hFFFF);
        run_vec(vecs[8], "sat2");
        chk("sat hold", CorrCnt, 16'hFFFF);

        // ClrCnt coincident with a corrected output transfer
        ValidIn = 1'b1;
        CodeIn  = 18'h00020;
        @(negedge CLK);
        ValidIn = 1'b0;
        @(negedge CLK);
        chk("clrx valid", ValidOut, 1'b1);
        chk("clrx corr", Corrected, 1'b1);
        ClrCnt = 1'b1;
        @(negedge CLK);
        ClrCnt = 1'b0;
        chk("clrx corrcnt", CorrCnt, 16'h0);
        chk("clrx unccnt", UncCnt, 16'h0);
        chk("clrx drained", ValidOut, 1'b0);
        exp_cc = '0;
        exp_uc = '0;

        // Mid-operation reset with both stages full
        run_vec(vecs[2], "mr unc");
        run_vec(vecs[0], "mr corr");
        ReadyIn = 1'b0;
        ValidIn = 1'b1;
        CodeIn  = 18'h00020;
        @(negedge CLK);
        CodeIn  = 18'h00007;
        @(negedge CLK);
        ValidIn = 1'b0;
        chk("mr full valid", ValidOut, 1'b1);
        chk("mr full ready", ReadyOut, 1'b0);
        chk("mr full pos", ErrPos, 5'd5);
        #2 RST_N = 1'b0;
        #1;
        chk("mr async validout", ValidOut, 1'b0);
        chk("mr async flags", {Corrected, Uncorrectable, ErrPos}, 7'h0);
        chk("mr async data", DataOut, 12'h000);
        chk("mr async cnts", {CorrCnt, UncCnt}, 32'h0);
        chk("mr readyout", ReadyOut, 1'b1);
        @(negedge CLK);
        RST_N   = 1'b1;
        ReadyIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("mr no stale", ValidOut, 1'b0);
        end
        chk("mr cnts after", {CorrCnt, UncCnt}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
